// File: rtl/opb_master_pkg.sv
// Shared definitions for the single-beat OPB master.
// Contents: FSM state encoding, default bus widths, byte-enable width
// helper and the response codes held between transactions.
package opb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned DEF_AWIDTH = 32;
  localparam int unsigned DEF_DWIDTH = 32;

  // Response codes latched when a transaction leaves XFER.
  localparam logic [1:0] RSP_OK   = 2'b00;
  localparam logic [1:0] RSP_ERR  = 2'b01;
  localparam logic [1:0] RSP_TOUT = 2'b10;

  function automatic int unsigned be_width(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/opb_master_tout_ctr.sv
// Local data-phase timeout counter.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   clr_i   hold the count at zero (asserted whenever the master is not in XFER)
//   en_i    advance the count (deasserted while the slave suppresses timeout)
//   term_o  count has reached C_TIMEOUT-1
module opb_master_tout_ctr #(
  parameter int unsigned C_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int unsigned CW = $clog2(C_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CW'(C_TIMEOUT - 1));

  // Saturate at the terminal value so a long suppression cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/opb_master_single.sv
// Single-beat OPB bus master for fabric user logic.
// User side : cmd_valid/cmd_ready handshake (accepted on a clock edge where
//             both are high; cmd_ready is high only in IDLE), command fields
//             cmd_rnw/addr/wdata/be. Completion is a one-cycle rsp_valid pulse
//             with rsp_rdata/rsp_err/rsp_timeout; there is no backpressure.
// Bus side  : M_request/M_select/M_RNW/M_ABus/M_BE/M_DBus driven onto the
//             OR-bus (all zero while not selected), M_seqAddr/M_busLock tied 0,
//             OPB_MGrant/xferAck/errAck/retry/toutSup/timeout/DBus sampled.
// Debug     : dbg_state_o exposes the FSM state.
module opb_master_single
  import opb_master_pkg::*;
#(
  parameter int unsigned C_OPB_AWIDTH = DEF_AWIDTH,
  parameter int unsigned C_OPB_DWIDTH = DEF_DWIDTH,
  parameter int unsigned C_TIMEOUT    = 16,
  parameter int unsigned C_MAX_RETRY  = 8,
  parameter              C_FAMILY     = "virtex6",
  localparam int unsigned BW          = be_width(C_OPB_DWIDTH)
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rnw,
  input  logic [0:C_OPB_AWIDTH-1] cmd_addr,
  input  logic [0:C_OPB_DWIDTH-1] cmd_wdata,
  input  logic [0:BW-1]          cmd_be,
  output logic                   rsp_valid,
  output logic [0:C_OPB_DWIDTH-1] rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   M_request,
  output logic                   M_select,
  output logic                   M_RNW,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:BW-1]          M_BE,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  output logic                   M_seqAddr,
  output logic                   M_busLock,
  input  logic                   OPB_MGrant,
  input  logic                   OPB_xferAck,
  input  logic                   OPB_errAck,
  input  logic                   OPB_retry,
  input  logic                   OPB_toutSup,
  input  logic                   OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  output state_e                 dbg_state_o
);

  localparam int unsigned RCW = $clog2(C_MAX_RETRY + 1);

  // The family name only travels with the core for tool flows.
  if (C_FAMILY == "") begin : g_no_family
  end

  state_e                  state_q, state_d;
  logic                    rnw_q;
  logic [0:C_OPB_AWIDTH-1] addr_q;
  logic [0:C_OPB_DWIDTH-1] wdata_q;
  logic [0:BW-1]           be_q;
  logic [RCW-1:0]          retry_q;
  logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_d;
  logic [1:0]              code_q, code_d;
  logic                    rsp_upd, retry_inc, retry_last, tout_term, accept;

  assign accept     = (state_q == ST_IDLE) && cmd_valid;
  assign retry_last = (retry_q == RCW'(C_MAX_RETRY - 1));

  opb_master_tout_ctr #(.C_TIMEOUT(C_TIMEOUT)) u_tout (
    .clk_i  (OPB_Clk),
    .rst_ni (OPB_Rst),
    .clr_i  (state_q != ST_XFER),
    .en_i   ((state_q == ST_XFER) && !OPB_toutSup),
    .term_o (tout_term)
  );

  // Data-phase termination, in priority order: errAck, xferAck, retry, timeout.
  always_comb begin
    rsp_upd   = 1'b0;
    retry_inc = 1'b0;
    rdata_d   = '0;
    code_d    = RSP_OK;
    if (state_q == ST_XFER) begin
      if (OPB_errAck) begin
        rsp_upd = 1'b1;
        code_d  = RSP_ERR;
      end else if (OPB_xferAck) begin
        rsp_upd = 1'b1;
        rdata_d = rnw_q ? OPB_DBus : '0;
      end else if (OPB_retry) begin
        if (retry_last) begin
          rsp_upd = 1'b1;
          code_d  = RSP_ERR;
        end else begin
          retry_inc = 1'b1;
        end
      end else if (OPB_timeout || (tout_term && !OPB_toutSup)) begin
        rsp_upd = 1'b1;
        code_d  = RSP_TOUT;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid)  state_d = ST_REQ;
      ST_REQ:  if (OPB_MGrant) state_d = ST_XFER;
      ST_XFER: begin
        if (rsp_upd)        state_d = ST_RESP;
        else if (retry_inc) state_d = ST_REQ;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Bus fields are gated by select so idle cycles put zeros on the OR-bus.
  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    M_request   = (state_q == ST_REQ);
    M_select    = (state_q == ST_XFER);
    rsp_valid   = (state_q == ST_RESP);
    M_RNW       = M_select && rnw_q;
    M_ABus      = M_select ? addr_q : '0;
    M_BE        = M_select ? be_q : '0;
    M_DBus      = (M_select && !rnw_q) ? wdata_q : '0;
    M_seqAddr   = 1'b0;
    M_busLock   = 1'b0;
    rsp_rdata   = rdata_q;
    rsp_err     = (code_q == RSP_ERR);
    rsp_timeout = (code_q == RSP_TOUT);
    dbg_state_o = state_q;
  end

  // Holding registers, retry count and the latched response.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      retry_q <= '0;
      rdata_q <= '0;
      code_q  <= RSP_OK;
    end else begin
      if (accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        be_q    <= cmd_be;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (rsp_upd) begin
        rdata_q <= rdata_d;
        code_q  <= code_d;
      end
    end
  end

endmodule

// File: doc/opb_master_single.md
Name: opb_master_single

Overview:
- OPB bus master issuing single-beat 32-bit read/write transactions on behalf of fabric user logic.
- Initiator counterpart to the team's OPB slave register cores (ppc2simulink family), for fabric-driven register access and self-test of slave peripherals.
- Lives on the shared OPB bus beside the PPC master; arbiter-granted.
- Handles grant, ack/errAck, retry and timeout, then returns a one-cycle response.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width. Byte enables are C_OPB_DWIDTH/8.
- C_TIMEOUT, 16, cycles in XFER without ack before a local timeout (≥2).
- C_MAX_RETRY, 8, OPB_retry responses tolerated before reporting an error (≥1).
- C_FAMILY, "virtex6", target family (informational).

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  user command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [0:31]  byte address.
- cmd_wdata  in  [0:31]  write data.
- cmd_be  in  [0:3]  byte enables.
- rsp_valid  out  1  one-cycle completion pulse (no backpressure).
- rsp_rdata  out  [0:31]  read data; 0 for writes and failures.
- rsp_err  out  1  errAck received or retry limit hit.
- rsp_timeout  out  1  local or OPB_timeout termination.
- M_request  out  1  bus request.
- M_select  out  1  master select.
- M_RNW  out  1  direction.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  tied 0.
- M_busLock  out  1  tied 0.
- OPB_MGrant  in  1  arbiter grant.
- OPB_xferAck  in  1  slave ack.
- OPB_errAck  in  1  slave error.
- OPB_retry  in  1  slave retry.
- OPB_toutSup  in  1  timeout suppress.
- OPB_timeout  in  1  bus monitor timeout.
- OPB_DBus  in  [0:31]  read data.

Behaviour:
- Reset (OPB_Rst=0 at clock edge), and every output in that cycle:
  - state → IDLE.
  - All outputs 0 except cmd_ready=1.
  - Counters cleared.
  - An in-flight transaction is abandoned with no rsp_valid.
- OR-bus rule: M_ABus, M_BE, M_RNW and M_DBus are all 0 whenever M_select=0. M_DBus is also 0 during reads.
- FSM states: IDLE, REQ, XFER, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid latches rnw/addr/wdata/be into holding registers, clears retry_cnt, next state REQ.
- REQ:
  - M_request=1.
  - OPB_MGrant=1 → next XFER; M_request drops and M_select rises in the same edge.
- XFER:
  - M_select=1, bus driven from the holding registers.
  - tout_cnt cleared on entry; increments each cycle unless OPB_toutSup=1 (frozen).
  - Per-cycle priority:
    1. errAck: RESP, err=1, rdata=0.
    2. xferAck: RESP; rdata=OPB_DBus if read, else 0.
    3. retry: if retry_cnt=C_MAX_RETRY-1 → RESP, err=1; otherwise retry_cnt++ and back to REQ with M_select=0 next cycle.
    4. OPB_timeout, or tout_cnt=C_TIMEOUT-1 with toutSup=0: RESP, timeout=1.
  - errAck with xferAck in the same cycle: error wins, data discarded.
- RESP:
  - rsp_valid=1 for exactly one cycle, M_select=0, next IDLE.
  - rsp_rdata/err/timeout hold until the next RESP; they are valid only with rsp_valid.
- Latency: with immediate grant and ack, command accepted at T → M_select at T+2 → rsp_valid at T+3.
- Commands are ignored while cmd_ready=0 (no queue).
- Grant received outside REQ is ignored.

Decomposition:
- opb_master_pkg holds:
  - state enum.
  - Default widths.
  - BE width function.
  - Response-code constants.
- One sub-module, opb_master_tout_ctr: C_TIMEOUT counter with freeze/clear and terminal flag.

Test Plan:
- Write, grant at 1st REQ cycle, xferAck at 1st XFER cycle:
  - Bus shows A=0x01106000, D=0xDEADBEEF, BE=F, RNW=0.
  - rsp_valid at T+3, err=0.
- Read, grant after 4 cycles, ack on XFER cycle 2 with OPB_DBus=0x12345678:
  - rsp_rdata=0x12345678.
  - M_DBus stays 0 throughout.
- Retry limit: slave returns retry every time with C_MAX_RETRY=8:
  - Exactly 8 select phases.
  - rsp_err=1, rsp_timeout=0.
- No ack, C_TIMEOUT=16:
  - rsp_timeout=1 after 16 XFER cycles.
  - Repeat with toutSup held 10 cycles: timeout after 26.
- errAck and xferAck in the same cycle on a read:
  - rsp_err=1, rsp_rdata=0.
- OPB_Rst=0 during XFER:
  - Next cycle all M_* outputs 0, cmd_ready=1, no rsp_valid.
  - A new command then completes normally.
